// File: rtl/sar_cmp_ctrl_pkg.sv
// Shared types and defaults for the successive-approximation comparator controller.
// Holds the FSM state enum, the default parameter values and the comparator polarity.
package sar_cmp_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_EVAL   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_SETTLE_CYC = 2;
   localparam int DEF_EVAL_CYC   = 3;

   // Level that cmp_in takes when the analog input is above the DAC output.
   localparam logic CMP_ABOVE = 1'b1;

endpackage

// File: rtl/sar_cmp_ctrl_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
// Brings the raw latched-comparator output into the clk domain.
module cmp_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sar_cmp_ctrl.sv
// SAR conversion sequencer: drives the DAC trial code and the comparator enable,
// and resolves one bit per SETTLE+EVAL step, MSB first.
//
// Handshake: start is level-sampled and is only honoured in IDLE. abort cancels a
// running conversion on the next edge. done pulses for one cycle exactly when
// result is updated. There is no ready/backpressure path.
module sar_cmp_ctrl
   import sar_cmp_ctrl_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int EVAL_CYC   = DEF_EVAL_CYC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_in,
   output logic             cmp_en,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       dbg_state
);

   localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int PMAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [WIDTH-1:0] code_q, code_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cmp_en_q, busy_q, done_q;
   logic             cmp_sync;
   logic             bit_d;
   logic [IW-1:0]    idx_m1;

   cmp_sync2 u_cmp_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (cmp_in),
      .q_o   (cmp_sync)
   );

   assign bit_d  = (cmp_sync == CMP_ABOVE);
   assign idx_m1 = idx_q - IW'(1);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      phase_d  = phase_q;
      code_d   = code_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            // abort together with start keeps the controller idle
            if (start && !abort) begin
               state_d            = ST_SETTLE;
               idx_d              = IW'(WIDTH-1);
               code_d             = '0;
               code_d[WIDTH-1]    = 1'b1;
               phase_d            = PW'(SETTLE_CYC-1);
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               code_d  = '0;
            end else if (phase_q == '0) begin
               state_d = ST_EVAL;
               phase_d = PW'(EVAL_CYC-1);
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         ST_EVAL: begin
            if (abort) begin
               state_d = ST_IDLE;
               code_d  = '0;
            end else if (phase_q == '0) begin
               code_d[idx_q] = bit_d;
               if (idx_q != '0) begin
                  code_d[idx_m1] = 1'b1;
                  idx_d          = idx_m1;
                  phase_d        = PW'(SETTLE_CYC-1);
                  state_d        = ST_SETTLE;
               end else begin
                  result_d = code_d;
                  state_d  = ST_DONE;
               end
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         phase_q  <= '0;
         code_q   <= '0;
         result_q <= '0;
         cmp_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         phase_q  <= phase_d;
         code_q   <= code_d;
         result_q <= result_d;
         cmp_en_q <= (state_d == ST_EVAL);
         busy_q   <= (state_d == ST_SETTLE) || (state_d == ST_EVAL);
         done_q   <= (state_d == ST_DONE);
      end
   end

   assign cmp_en    = cmp_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dac_code  = code_q;
   assign result    = result_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sar_cmp_ctrl.sv
// Self-checking bench for sar_cmp_ctrl at default parameters, with an
// idealised comparator/DAC model driven from a target code.
module tb_sar_cmp_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         cmp_in;
   logic         cmp_en;
   logic [W-1:0] dac_code;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [1:0]   dbg_state;

   logic [W-1:0] target = '0;
   logic         noise_en = 1'b0;
   logic         noise = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];

   typedef struct {
      logic [W-1:0] tgt;
      logic [W-1:0] res;
   } vec_t;
   vec_t vecs[5];

   sar_cmp_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cmp_in    (cmp_in),
      .cmp_en    (cmp_en),
      .dac_code  (dac_code),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / comparator model ----------------
   always #5 clk = ~clk;

   always begin
      #3;
      noise = 1'($urandom_range(0, 1));
   end

   // Analog input sits half an LSB above the target code, so a trial equal
   // to the target still reads as "input above DAC".
   assign cmp_in = cmp_en ? (target >= dac_code) : (noise_en & noise);

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Binary search over the code space: the ideal SAR trial sequence and result.
   function automatic logic [W-1:0] model(input logic [W-1:0] tgt);
      logic [W-1:0] code;
      logic [W-1:0] trial;
      code = '0;
      exp_q.delete();
      for (int b = W - 1; b >= 0; b--) begin
         trial = code | (W'(1) << b);
         exp_q.push_back(trial);
         if (tgt >= trial) code = trial;
      end
      return code;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic run_conv(input logic [W-1:0] tgt, input logic [W-1:0] exp_res, input string tag);
      logic [W-1:0] mres;
      int busy_cnt;
      int done_k;
      mres = model(tgt);
      got_q.delete();
      busy_cnt = 0;
      done_k = -1;
      target = tgt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 80; k++) begin
         if (busy) busy_cnt++;
         if (cmp_en && (got_q.size() == 0 || got_q[$] != dac_code)) got_q.push_back(dac_code);
         if (done) begin
            done_k = k;
            break;
         end
         @(negedge clk);
      end
      if (done_k < 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=nodone required=done", tag);
      end else begin
         check({tag, "_done_cycle"}, done_k, 40);
         check({tag, "_busy_cycles"}, busy_cnt, 40);
         check({tag, "_result"}, result, exp_res);
         check({tag, "_model"}, result, mres);
         check({tag, "_trial_count"}, got_q.size(), exp_q.size());
         for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
            check({tag, "_trial"}, got_q[j], exp_q[j]);
         @(negedge clk);
         check({tag, "_done_width"}, done, 0);
      end
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      int done_ks[$];
      vecs[0] = '{tgt: 8'hA5, res: 8'hA5};
      vecs[1] = '{tgt: 8'h00, res: 8'h00};
      vecs[2] = '{tgt: 8'hFF, res: 8'hFF};
      vecs[3] = '{tgt: 8'h3C, res: 8'h3C};
      vecs[4] = '{tgt: 8'h5A, res: 8'h5A};

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmp_en", cmp_en, 0);
      check("rst_dac", dac_code, 0);
      check("rst_result", result, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // table-driven conversions
      for (int v = 0; v < 5; v++) run_conv(vecs[v].tgt, vecs[v].res, "vec");

      // randomized conversions against the model
      for (int r = 0; r < 8; r++) begin
         logic [W-1:0] t;
         t = W'($urandom_range(0, 255));
         run_conv(t, model(t), "rand");
      end

      // abort mid-conversion leaves result intact and gives no done
      run_conv(8'h3C, 8'h3C, "pre_abort");
      target = 8'h81;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (12) @(negedge clk);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_cmp_en", cmp_en, 0);
      check("abort_dac", dac_code, 0);
      check("abort_done", done, 0);
      count_done(60, n);
      check("abort_no_done", n, 0);
      check("abort_result", result, 8'h3C);

      // abort together with start in idle: nothing starts
      @(negedge clk) begin start = 1'b1; abort = 1'b1; end
      @(negedge clk) begin start = 1'b0; abort = 1'b0; end
      check("abort_start_idle_busy", busy, 0);
      count_done(50, n);
      check("abort_start_idle_done", n, 0);

      // start pulse during busy produces no extra conversion
      target = 8'h42;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      count_done(100, n);
      check("busy_start_done_count", n, 1);
      check("busy_start_result", result, 8'h42);

      // start held high: back-to-back conversions
      target = 8'h55;
      @(negedge clk) start = 1'b1;
      for (int k = 1; k <= 140; k++) begin
         @(negedge clk);
         if (done) done_ks.push_back(k);
      end
      start = 1'b0;
      check("b2b_count", done_ks.size(), 3);
      for (int j = 1; j < done_ks.size(); j++) check("b2b_spacing", done_ks[j] - done_ks[j-1], 42);
      check("b2b_result", result, 8'h55);
      for (int k = 0; k < 60 && busy; k++) @(negedge clk);
      check("b2b_idle", busy, 0);
      @(negedge clk);

      // asynchronous reset mid-EVAL
      target = 8'h77;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (23) @(negedge clk);
      check("pre_rst_cmp_en", cmp_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_cmp_en", cmp_en, 0);
      check("arst_dac", dac_code, 0);
      check("arst_done", done, 0);
      check("arst_result", result, 0);
      @(negedge clk) rst_n = 1'b1;
      run_conv(8'h5A, 8'h5A, "post_rst");

      // comparator noise outside EVAL must not affect decisions
      noise_en = 1'b1;
      run_conv(8'hA5, 8'hA5, "noise_a5");
      run_conv(8'h3C, 8'h3C, "noise_3c");
      run_conv(8'h00, 8'h00, "noise_00");
      noise_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
